// File: rtl/core_pkg.sv
// Shared core definitions: write-size encodings, MMIO offsets, STATUS layout
// and byte-lane helpers for the data-memory responder.
`default_nettype none

package core_pkg;

  localparam logic [1:0] WSIZE_B = 2'd0;
  localparam logic [1:0] WSIZE_H = 2'd1;
  localparam logic [1:0] WSIZE_W = 2'd2;

  localparam logic [31:0] CON_DATA = 32'h0;
  localparam logic [31:0] STATUS   = 32'h4;
  localparam logic [31:0] CYCLE    = 32'h8;

  localparam int ST_MISALIGN = 7;
  localparam int ST_OVERFLOW = 6;
  localparam int ST_FULL     = 5;
  localparam int ST_EMPTY    = 4;

  function automatic logic [3:0] byte_en(input logic [1:0] wsize, input logic [1:0] lo);
    case (wsize)
      WSIZE_B: byte_en = 4'b0001 << lo;
      WSIZE_H: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      WSIZE_W: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  // Right-justified write data is replicated so every enabled lane sees it.
  function automatic logic [31:0] lane_data(input logic [1:0] wsize, input logic [31:0] wdata);
    case (wsize)
      WSIZE_B: lane_data = {4{wdata[7:0]}};
      WSIZE_H: lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
`default_nettype none

module dmem_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     dropped,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dropped = push & ~do_push;
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// Data-memory responder: zero-latency word RAM with sized writes plus an MMIO
// window holding a console FIFO, a status register and a cycle counter.
`default_nettype none

module dmem_ctrl
  import core_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_raddr_i,
  output logic [31:0] mem_rdata_o,
  input  logic [31:0] mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [1:0]  mem_wsize_i,
  input  logic        mem_wen_i,
  output logic [7:0]  con_data_o,
  output logic        con_valid_o,
  input  logic        con_ready_i,
  output logic        err_o
);

  localparam int          IW        = $clog2(DEPTH_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [29:0] RAM_WORDS = 30'(DEPTH_WORDS);
  localparam logic [31:0] CON_ADDR  = MMIO_BASE + CON_DATA;
  localparam logic [31:0] STAT_ADDR = MMIO_BASE + STATUS;
  localparam logic [31:0] CYC_ADDR  = MMIO_BASE + CYCLE;

  logic [31:0]   ram [DEPTH_WORDS];
  logic [31:0]   cycle_cnt;
  logic          misalign;
  logic          overflow;

  logic          misalign_evt;
  logic          overflow_evt;
  logic          write_ok;
  logic          ram_whit;
  logic          ram_rhit;
  logic          con_whit;
  logic          stat_whit;
  logic          status_clr;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic [IW-1:0] widx;
  logic [IW-1:0] ridx;
  logic [31:0]   status_word;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_dropped;
  logic [CW-1:0] fifo_count;

  // The core extracts sub-word fields itself, so the low read address bits
  // carry no information here.
  logic unused_raddr_lo;
  assign unused_raddr_lo = ^mem_raddr_i[1:0];

  always_comb begin
    misalign_evt = 1'b0;
    if (mem_wen_i) begin
      case (mem_wsize_i)
        WSIZE_B: misalign_evt = 1'b0;
        WSIZE_H: misalign_evt = mem_waddr_i[0];
        WSIZE_W: misalign_evt = |mem_waddr_i[1:0];
        default: misalign_evt = 1'b1;
      endcase
    end
  end

  assign write_ok   = mem_wen_i & ~misalign_evt;
  assign ram_whit   = (mem_waddr_i[31:2] < RAM_WORDS);
  assign ram_rhit   = (mem_raddr_i[31:2] < RAM_WORDS);
  assign con_whit   = (mem_waddr_i[31:2] == CON_ADDR[31:2]);
  assign stat_whit  = (mem_waddr_i[31:2] == STAT_ADDR[31:2]);
  assign status_clr = write_ok & stat_whit & mem_wdata_i[0];
  assign be         = byte_en(mem_wsize_i, mem_waddr_i[1:0]);
  assign wlanes     = lane_data(mem_wsize_i, mem_wdata_i);
  assign widx       = mem_waddr_i[IW+1:2];
  assign ridx       = mem_raddr_i[IW+1:2];

  always_ff @(posedge clk) begin
    if (write_ok && ram_whit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[widx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  assign fifo_push    = write_ok & con_whit;
  assign fifo_pop     = con_valid_o & con_ready_i;
  assign overflow_evt = fifo_dropped;
  assign con_valid_o  = ~fifo_empty;

  dmem_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .din     (mem_wdata_i[7:0]),
    .pop     (fifo_pop),
    .dout    (con_data_o),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .dropped (fifo_dropped),
    .count   (fifo_count)
  );

  // A fresh error in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (misalign_evt)    misalign <= 1'b1;
      else if (status_clr) misalign <= 1'b0;
      if (overflow_evt)    overflow <= 1'b1;
      else if (status_clr) overflow <= 1'b0;
    end
  end

  assign err_o = misalign | overflow;

  always_ff @(posedge clk) begin
    if (rst) cycle_cnt <= '0;
    else     cycle_cnt <= cycle_cnt + 32'd1;
  end

  always_comb begin
    status_word              = '0;
    status_word[ST_MISALIGN] = misalign;
    status_word[ST_OVERFLOW] = overflow;
    status_word[ST_FULL]     = fifo_full;
    status_word[ST_EMPTY]    = fifo_empty;
    status_word[3:0]         = 4'(fifo_count);
  end

  always_comb begin
    mem_rdata_o = '0;
    if (ram_rhit)                                  mem_rdata_o = ram[ridx];
    else if (mem_raddr_i[31:2] == STAT_ADDR[31:2]) mem_rdata_o = status_word;
    else if (mem_raddr_i[31:2] == CYC_ADDR[31:2])  mem_rdata_o = cycle_cnt;
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: RAM sized writes, alignment errors,
// console FIFO overflow/drain, reset behaviour and the cycle counter.
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_ctrl;
  import core_pkg::*;

  localparam logic [31:0] MB = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_raddr_i = '0;
  logic [31:0] mem_rdata_o;
  logic [31:0] mem_waddr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [1:0]  mem_wsize_i = '0;
  logic        mem_wen_i = 1'b0;
  logic [7:0]  con_data_o;
  logic        con_valid_o;
  logic        con_ready_i = 1'b0;
  logic        err_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd_q [$];
  logic [7:0]  con_q [$];
  logic [31:0] got;
  logic [31:0] ex;
  logic [7:0]  exb;

  dmem_ctrl #(
    .DEPTH_WORDS (1024),
    .MMIO_BASE   (MB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_raddr_i (mem_raddr_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_waddr_i (mem_waddr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_wsize_i (mem_wsize_i),
    .mem_wen_i   (mem_wen_i),
    .con_data_o  (con_data_o),
    .con_valid_o (con_valid_o),
    .con_ready_i (con_ready_i),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    mem_waddr_i = a;
    mem_wdata_i = d;
    mem_wsize_i = s;
    mem_wen_i   = 1'b1;
    @(posedge clk);
    #1;
    mem_wen_i   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    mem_raddr_i = a;
    #1;
    d = mem_rdata_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (con_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", con_valid_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    total++; if (con_data_o !== 8'h00) begin bad++; $display("FAIL reset_con_data: got %h want 00", con_data_o); end
    rd_q.push_back(32'h0000_0010);
    rd(MB + STATUS, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL reset_status: got %h want %h", got, ex); end
    rd_q.push_back(32'd0);
    rd(MB + CYCLE, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL cycle_at_0: got %h want %h", got, ex); end
    repeat (5) idle();
    rd_q.push_back(32'd5);
    rd(MB + CYCLE, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL cycle_at_5: got %h want %h", got, ex); end
    idle();
  endtask

  task automatic test_word_byte();
    wr(32'h10, 32'hDEAD_BEEF, WSIZE_W);
    mem_waddr_i = 32'h11;
    mem_wdata_i = 32'h0000_0055;
    mem_wsize_i = WSIZE_B;
    mem_wen_i   = 1'b1;
    rd_q.push_back(32'hDEAD_BEEF);
    rd(32'h10, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL read_during_write: got %h want %h", got, ex); end
    @(posedge clk);
    #1;
    mem_wen_i = 1'b0;
    rd_q.push_back(32'hDEAD_55EF);
    rd(32'h10, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL byte_merge: got %h want %h", got, ex); end
    idle();
  endtask

  task automatic test_half();
    wr(32'h20, 32'hAAAA_BBBB, WSIZE_W);
    wr(32'h22, 32'h0000_1234, WSIZE_H);
    rd_q.push_back(32'h1234_BBBB);
    rd(32'h20, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL half_upper: got %h want %h", got, ex); end
    wr(32'h23, 32'h0000_0099, WSIZE_B);
    rd_q.push_back(32'h9934_BBBB);
    rd(32'h20, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL byte_lane3: got %h want %h", got, ex); end
    idle();
  endtask

  task automatic test_misalign();
    wr(32'h21, 32'h0000_FFFF, WSIZE_H);
    rd_q.push_back(32'h9934_BBBB);
    rd(32'h20, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL half_misalign_dropped: got %h want %h", got, ex); end
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL misalign_err: got %b want 1", err_o); end
    rd_q.push_back(32'h0000_0090);
    rd(MB + STATUS, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL misalign_status: got %h want %h", got, ex); end
    wr(32'h22, 32'h0000_0000, WSIZE_W);
    wr(32'h20, 32'h0000_0000, 2'd3);
    rd_q.push_back(32'h9934_BBBB);
    rd(32'h20, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL word_misalign_dropped: got %h want %h", got, ex); end
    wr(MB + STATUS, 32'h1, WSIZE_W);
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL status_clear_err: got %b want 0", err_o); end
    wr(32'h2000_0000, 32'h1234, WSIZE_W);
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL unmapped_no_err: got %b want 0", err_o); end
    rd_q.push_back(32'h0);
    rd(32'h2000_0000, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL unmapped_read: got %h want %h", got, ex); end
    rd_q.push_back(32'h0);
    rd(MB + CON_DATA, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL con_data_read: got %h want %h", got, ex); end
    idle();
  endtask

  task automatic test_overflow();
    logic [7:0] c;
    con_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c = 8'h41 + 8'(i);
      wr(MB + CON_DATA, {24'h0, c}, WSIZE_B);
      con_q.push_back(c);
      if (i == 0) begin
        total++; if (con_valid_o !== 1'b1) begin bad++; $display("FAIL push_valid: got %b want 1", con_valid_o); end
      end
    end
    total++; if (con_data_o !== con_q[0]) begin bad++; $display("FAIL fifo_head: got %h want %h", con_data_o, con_q[0]); end
    rd_q.push_back(32'h0000_0024);
    rd(MB + STATUS, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL full_status: got %h want %h", got, ex); end
    wr(MB + CON_DATA, 32'h45, WSIZE_B);
    rd_q.push_back(32'h0000_0064);
    rd(MB + STATUS, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL overflow_status: got %h want %h", got, ex); end
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL overflow_err: got %b want 1", err_o); end
    idle();
    total++; if (con_data_o !== con_q[0]) begin bad++; $display("FAIL head_stable: got %h want %h", con_data_o, con_q[0]); end
    wr(MB + STATUS, 32'h1, WSIZE_W);
    rd_q.push_back(32'h0000_0024);
    rd(MB + STATUS, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL overflow_cleared: got %h want %h", got, ex); end
    idle();
  endtask

  task automatic test_push_pop_full();
    int guard;
    mem_waddr_i = MB + CON_DATA;
    mem_wdata_i = 32'h45;
    mem_wsize_i = WSIZE_B;
    mem_wen_i   = 1'b1;
    con_ready_i = 1'b1;
    #1;
    exb = con_q.pop_front();
    total++; if (con_valid_o !== 1'b1 || con_data_o !== exb) begin bad++; $display("FAIL pop_head: valid %b data %h want 1/%h", con_valid_o, con_data_o, exb); end
    con_q.push_back(8'h45);
    @(posedge clk);
    #1;
    mem_wen_i   = 1'b0;
    con_ready_i = 1'b0;
    rd_q.push_back(32'h0000_0024);
    rd(MB + STATUS, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL pushpop_status: got %h want %h", got, ex); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL pushpop_no_overflow: got %b want 0", err_o); end
    con_ready_i = 1'b1;
    guard = 0;
    while (con_q.size() > 0 && guard < 20) begin
      if (con_valid_o) begin
        exb = con_q.pop_front();
        total++; if (con_data_o !== exb) begin bad++; $display("FAIL drain_order: got %h want %h", con_data_o, exb); end
      end
      idle();
      guard++;
    end
    con_ready_i = 1'b0;
    total++; if (con_q.size() != 0) begin bad++; $display("FAIL drain_timeout: left %0d want 0", con_q.size()); end
    con_q.delete();
    total++; if (con_valid_o !== 1'b0 || con_data_o !== 8'h00) begin bad++; $display("FAIL drained_idle: valid %b data %h want 0/00", con_valid_o, con_data_o); end
    idle();
  endtask

  task automatic test_rst_mid_drain();
    wr(MB + CON_DATA, 32'h58, WSIZE_B);
    wr(MB + CON_DATA, 32'h59, WSIZE_B);
    con_ready_i = 1'b1;
    rst = 1'b1;
    idle();
    rst = 1'b0;
    con_ready_i = 1'b0;
    total++; if (con_valid_o !== 1'b0) begin bad++; $display("FAIL rst_drain_valid: got %b want 0", con_valid_o); end
    rd_q.push_back(32'h0000_0010);
    rd(MB + STATUS, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL rst_drain_status: got %h want %h", got, ex); end
    idle();
  endtask

  task automatic test_cycle_wrap();
    @(negedge clk);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    release dut.cycle_cnt;
    rd_q.push_back(32'hFFFF_FFFF);
    rd(MB + CYCLE, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL cycle_forced: got %h want %h", got, ex); end
    idle();
    rd_q.push_back(32'h0);
    rd(MB + CYCLE, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL cycle_wrap: got %h want %h", got, ex); end
    idle();
    rd_q.push_back(32'h1);
    rd(MB + CYCLE, got); ex = rd_q.pop_front();
    total++; if (got !== ex) begin bad++; $display("FAIL cycle_after_wrap: got %h want %h", got, ex); end
  endtask

  initial begin
    test_reset();
    test_word_byte();
    test_half();
    test_misalign();
    test_overflow();
    test_push_pop_full();
    test_rst_mid_drain();
    test_cycle_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder for the single-cycle core. It answers the execute unit's memory read/write interface: it holds a word-organised data RAM with byte-lane sized writes and a small MMIO window. The window carries a console byte FIFO with a valid/ready drain port, a status register and a free-running cycle counter. It sits beside the register file at core level and connects to the core's `mem_*` signals.

## Interface
- `DEPTH_WORDS`, 1024: data RAM depth in 32-bit words; RAM occupies byte addresses 0 .. 4*DEPTH_WORDS-1.
- `MMIO_BASE`, 32'h1000_0000: base of the MMIO window (CON_DATA +0x0, STATUS +0x4, CYCLE +0x8).
- `FIFO_DEPTH`, 4: console FIFO entries; must be a power of two, ≥2.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_raddr_i`  in  32  read byte address.
- `mem_rdata_o`  out  32  read data, whole aligned word.
- `mem_waddr_i`  in  32  write byte address.
- `mem_wdata_i`  in  32  write data, right-justified (byte in [7:0], half in [15:0]).
- `mem_wsize_i`  in  2  write size: 0 byte, 1 half, 2 word, 3 reserved.
- `mem_wen_i`  in  1  write enable.
- `con_data_o`  out  8  console FIFO head byte.
- `con_valid_o`  out  1  FIFO non-empty.
- `con_ready_i`  in  1  sink accepts head this cycle.
- `err_o`  out  1  OR of sticky misalign/overflow flags.

## Operation
- **Read path:**
  - Reads are combinational and have zero latency, because the core consumes read data in the same cycle.
  - RAM hit: return `ram[mem_raddr_i[..:2]]`; `raddr[1:0]` is ignored, and the core extracts bytes.
  - STATUS returns {24'b0, misalign, overflow, full, empty, count[3:0]}.
  - CYCLE returns the counter.
  - CON_DATA and any unmapped address return 0.
- **Write alignment:**
  - Word writes require `waddr[1:0]`=0.
  - Half writes require `waddr[0]`=0.
  - Byte writes are always aligned.
  - Misaligned writes and `wsize`=3 are dropped and set sticky `misalign`.
- **Byte enables (RAM writes):**
  - Byte: lane `waddr[1:0]`, data replicated ×4.
  - Half: lanes {`waddr[1]`*2, +1}, data replicated ×2.
  - Word: all lanes.
  - Write to an unmapped address: dropped, no flag.
- **CON_DATA write (any legal size):** pushes `wdata[7:0]`.
  - The push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and sticky `overflow` is set.
- **STATUS write:** if `wdata[0]`=1, clears both sticky flags. If a new error occurs in the same cycle, the new error wins.
- **CYCLE write:** ignored.
- **Pop:** occurs when `con_valid_o & con_ready_i`. The head advances, with pointer wrap modulo FIFO_DEPTH.
- **Cycle counter:** +1 every cycle, 32-bit, wraps from FFFF_FFFF to 0.
- **Reset:**
  - FIFO empty, pointers 0.
  - Counter 0, stickies 0.
  - `con_valid_o`=0, `err_o`=0, `con_data_o`=0 when empty.
  - RAM contents are not reset.

## Timing
- Writes commit at the rising edge where `mem_wen_i`=1.
- Read of the same address in the same cycle returns the old data; the new data is visible from the next cycle.
- A push is visible on `con_valid_o`/`con_data_o` the cycle after the write edge. There is no bypass, so an empty FIFO plus a push gives `con_valid_o`=1 on the next cycle.
- `con_data_o` is held stable while `con_valid_o`=1 and `con_ready_i`=0.
- The STATUS count reflects registered state, i.e. pre-edge values.
- `rst` asserted mid-drain empties the FIFO on that edge; the pending byte is lost.
- No wait states: every request completes in one cycle. The block has no stall output.

## Structure
- Shared `core_pkg` holds:
  - wsize encodings (`WSIZE_B`/`H`/`W`);
  - MMIO offsets (`CON_DATA`, `STATUS`, `CYCLE`);
  - STATUS bit positions.
- One sub-module, `dmem_fifo`: parameterised synchronous FIFO with push/pop/full/empty/count and simultaneous push-pop when full.
- RAM, decode and counter are inline in `dmem_ctrl`.

## Test plan
- Word write 0xDEADBEEF @0x10, then byte write 0x55 @0x11 → read @0x10 = 0xDEAD55EF; read in the write cycle returns the prior value.
- Half write 0x1234 @0x22 → word @0x20 upper half = 0x1234, lower unchanged.
- Half write @0x21 and word write @0x22 → RAM unchanged, `err_o`=1, STATUS bit7 set; STATUS write 1 → `err_o`=0 next cycle.
- Push 'A','B','C','D' with `con_ready_i`=0, then push 'E' → STATUS shows full/count 4; 'E' dropped, overflow set.
- Full FIFO plus push 'E' while `con_ready_i`=1 → 'A' pops, 'E' accepted, count stays 4; drain order B,C,D,E.
- Reset, then read CYCLE at cycles 0 and 5 → values differ by 5; force counter to FFFF_FFFF → next value 0.
